// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// Iterative multiply/divide unit with private HI/LO registers for the EX stage.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle, sign fixed up at the end.
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 div_q, div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_diff;
    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        logic signed [WIDTH-1:0] s;
        s = $signed(v);
        return (is_signed && s < 0) ? $unsigned(-s) : v;
    endfunction

    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        logic signed [WIDTH-1:0] s;
        s = $signed(v);
        return neg ? $unsigned(-s) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v,
                                                     input logic neg);
        logic signed [2*WIDTH-1:0] s;
        s = $signed(v);
        return neg ? $unsigned(-s) : v;
    endfunction

    assign mag1 = magnitude(data1_i, op_i[0]);
    assign mag2 = magnitude(data2_i, op_i[0]);

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opa_q};
    // Divide: acc = {partial remainder, remaining dividend bits / quotient bits}, shifted left.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_diff = rem_sh - {1'b0, opb_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;

        unique case (state_q)
            IDLE: begin
                if (hi_we_i) hi_d = wdata_i;
                if (lo_we_i) lo_d = wdata_i;
                if (start_i) begin
                    div_d     = op_i[1];
                    opa_d     = mag1;
                    opb_d     = mag2;
                    neg_res_d = op_i[0] & (data1_i[WIDTH-1] ^ data2_i[WIDTH-1]);
                    neg_rem_d = op_i[0] & op_i[1] & data1_i[WIDTH-1];
                    div0_d    = op_i[1] & (data2_i == '0);
                    acc_d     = {{WIDTH{1'b0}}, (op_i[1] ? mag1 : mag2)};
                    cnt_d     = CNT_W'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (div_q) begin
                    if (!rem_diff[WIDTH])
                        acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else if (acc_q[0]) begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                if (div_q) begin
                    lo_d = div0_q ? '1 : negate_w(acc_q[WIDTH-1:0], neg_res_q);
                    hi_d = negate_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
                end else begin
                    {hi_d, lo_d} = negate_2w(acc_q, neg_res_q);
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk_i) begin
        div_q     <= div_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        div0_q    <= div0_d;
        opa_q     <= opa_d;
        opb_q     <= opb_d;
        acc_q     <= acc_d;
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// Self-checking bench for muldiv_unit (WIDTH=32): scoreboard of expected {hi,lo} per accepted op.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] d1 = '0, d2 = '0, wdata = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [63:0] sb[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .data1_i(d1), .data2_i(d2), .hi_we_i(hi_we), .lo_we_i(lo_we),
        .wdata_i(wdata), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub;
        longint sa, sb2;
        int qa, qb, q, r;
        case (o)
            2'd0: begin ua = {32'h0, a}; ub = {32'h0, b}; return ua * ub; end
            2'd1: begin sa = $signed(a); sb2 = $signed(b); return 64'(sa * sb2); end
            2'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                qa = $signed(a); qb = $signed(b);
                q = qa / qb; r = qa % qb;
                return {32'(r), 32'(q)};
            end
        endcase
    endfunction

    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp);
        @(posedge clk); #1;
        start = 1'b1; op = o; d1 = a; d2 = b;
        sb.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output int bcyc);
        seen = 0; bcyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
            if (busy) bcyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_multu;
        bit seen; int bc; logic [63:0] exp;
        start_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        wait_done(seen, bc);
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL multu_done: no done_o within 100 cycles"); end
        n_cmp++; if (bc != 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
        exp = sb.pop_front();
        n_cmp++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL multu_result: got %h want %h", {hi, lo}, exp); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL multu_pulse: done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_mult;
        bit seen; int bc; logic [63:0] exp;
        start_op(2'd1, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB);
        wait_done(seen, bc);
        exp = sb.pop_front();
        n_cmp++; if (!seen || {hi, lo} !== exp) begin n_fail++; $display("FAIL mult_neg7x3: got %h (done %b) want %h", {hi, lo}, seen, exp); end
    endtask

    task automatic test_div;
        bit seen; int bc; logic [63:0] exp;
        logic [1:0]  ops[5] = '{2'd3, 2'd2, 2'd2, 2'd3, 2'd3};
        logic [31:0] as[5]  = '{32'hFFFF_FFF9, 32'd100, 32'h1234, 32'hFFFF_FF00, 32'h8000_0000};
        logic [31:0] bs[5]  = '{32'd2, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};
        logic [63:0] es[5]  = '{64'hFFFF_FFFF_FFFF_FFFD, {32'd2, 32'd14}, 64'h0000_1234_FFFF_FFFF,
                                64'hFFFF_FF00_FFFF_FFFF, 64'h0000_0000_8000_0000};
        for (int i = 0; i < 5; i++) begin
            start_op(ops[i], as[i], bs[i], es[i]);
            wait_done(seen, bc);
            exp = sb.pop_front();
            n_cmp++;
            if (!seen || {hi, lo} !== exp) begin
                n_fail++; $display("FAIL div_case%0d: got %h (done %b) want %h", i, {hi, lo}, seen, exp);
            end
        end
    endtask

    task automatic test_mthi_mtlo;
        bit seen; int bc; logic [63:0] exp;
        @(posedge clk); #1; hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1; hi_we = 1'b0;
        @(negedge clk);
        n_cmp++; if (hi !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mthi: got %h want a5a5a5a5", hi); end
        @(posedge clk); #1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A_0F0F;
        @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
        @(negedge clk);
        n_cmp++; if (hi !== 32'h5A5A_0F0F || lo !== 32'h5A5A_0F0F) begin n_fail++; $display("FAIL mthi_mtlo_both: got %h/%h want 5a5a0f0f", hi, lo); end
        start_op(2'd0, 32'd3, 32'd5, 64'd15);
        repeat (3) @(posedge clk);
        #1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1; lo_we = 1'b0;
        @(negedge clk);
        n_cmp++; if (lo !== 32'h5A5A_0F0F) begin n_fail++; $display("FAIL mtlo_busy: got %h want 5a5a0f0f", lo); end
        wait_done(seen, bc);
        exp = sb.pop_front();
        n_cmp++; if (!seen || {hi, lo} !== exp) begin n_fail++; $display("FAIL mtlo_busy_result: got %h want %h", {hi, lo}, exp); end
        @(posedge clk); #1;
        start = 1'b1; op = 2'd2; d1 = 32'd100; d2 = 32'd7; hi_we = 1'b1; wdata = 32'h1111_2222;
        sb.push_back({32'd2, 32'd14});
        @(posedge clk); #1; start = 1'b0; hi_we = 1'b0;
        @(negedge clk);
        n_cmp++; if (hi !== 32'h1111_2222) begin n_fail++; $display("FAIL start_with_mthi: got %h want 11112222", hi); end
        wait_done(seen, bc);
        exp = sb.pop_front();
        n_cmp++; if (!seen || {hi, lo} !== exp) begin n_fail++; $display("FAIL start_with_mthi_result: got %h want %h", {hi, lo}, exp); end
    endtask

    task automatic test_start_while_busy;
        bit seen, changed; logic [31:0] hb, lb; logic [63:0] exp;
        start_op(2'd1, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB);
        hb = hi; lb = lo; seen = 0; changed = 0;
        @(posedge clk); #1; start = 1'b1; op = 2'd3; d1 = 32'd5; d2 = 32'd0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; start = 1'b0; break; end
            if (hi !== hb || lo !== lb) changed = 1;
        end
        start = 1'b0;
        n_cmp++; if (changed) begin n_fail++; $display("FAIL hold_during_run: hi/lo changed while busy (now %h/%h)", hi, lo); end
        exp = sb.pop_front();
        n_cmp++; if (!seen || {hi, lo} !== exp) begin n_fail++; $display("FAIL busy_start_result: got %h (done %b) want %h", {hi, lo}, seen, exp); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_ignored: busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_run;
        int dc;
        start_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0);
        repeat (8) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        sb.delete();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrun_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL midrun_hilo: got %h/%h want 0/0", hi, lo); end
        dc = done_cnt;
        repeat (40) @(negedge clk);
        n_cmp++; if (done_cnt != dc) begin n_fail++; $display("FAIL midrun_no_done: got %0d pulses want 0", done_cnt - dc); end
    endtask

    task automatic test_random;
        bit seen; int bc; logic [63:0] exp;
        logic [1:0] o; logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            o = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
            if (o[1] && (i % 3 == 0)) b = b >> 26;
            if (i % 4 == 3) b = 32'h0;
            if (i == 5) begin o = 2'd3; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            start_op(o, a, b, model(o, a, b));
            wait_done(seen, bc);
            exp = sb.pop_front();
            n_cmp++;
            if (!seen || {hi, lo} !== exp) begin
                n_fail++; $display("FAIL random%0d op%0d %h,%h: got %h want %h", i, o, a, b, {hi, lo}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_start_while_busy();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with its own HI/LO registers, for the pipelined MIPS core's EX stage (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO).
- Successor to the single-cycle ALU path. Operand width is parametrised and the unit runs for many cycles.
- busy_o feeds the hazard-detection unit. While busy_o is high, that unit stalls PC and IF/ID for any dependent MFHI/MFLO or new mul/div.

Parameters:
- WIDTH, 32, operand width in bits. Must be at least 4 and even. hi_o and lo_o are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter. Derived from WIDTH and never overridden.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  request a new operation; sampled only in IDLE
- op_i  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start_i
- data1_i  in  WIDTH  multiplicand or dividend (rs)
- data2_i  in  WIDTH  multiplier or divisor (rt)
- hi_we_i  in  1  MTHI write strobe
- lo_we_i  in  1  MTLO write strobe
- wdata_i  in  WIDTH  MTHI/MTLO data
- busy_o  out  1  high while an operation is in progress
- done_o  out  1  one-cycle pulse when HI/LO take the result
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - rst_i is synchronous and active-high and has priority over everything else.
  - Reset values: state IDLE, busy_o 0, done_o 0, hi_o 0, lo_o 0, counter 0.
  - Reset asserted mid-operation aborts it. No done_o pulse is produced and HI/LO clear to 0.
- States: IDLE, RUN, FIX.
- IDLE:
  - If start_i=1: latch op_i.
  - Latch |data1_i| and |data2_i|. Magnitudes apply only for signed ops; unsigned ops latch the raw values.
  - Latch the result sign and the dividend sign.
  - Clear the accumulator and set counter=WIDTH, then go to RUN.
  - busy_o=1 from the next cycle.
- RUN, one iteration per cycle:
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH product.
  - Divide: restoring division, one quotient bit per cycle.
  - Counter decrements each cycle. At counter==1 the state goes to FIX.
- FIX, one cycle:
  - Apply the sign correction.
  - Write HI/LO, assert done_o=1, return to IDLE.
  - busy_o stays 1 during FIX and is 0 in the cycle after.
- Latency: with start accepted at edge N, done_o is high and HI/LO show the result in the cycle after edge N+WIDTH+1. busy_o is high for exactly WIDTH+1 cycles.
- Multiply result: {hi,lo} = full 2*WIDTH-bit product. MULT gives the two's-complement product, negated when the operand signs differ.
- Divide result: lo = quotient, hi = remainder.
  - DIV truncates toward zero.
  - The remainder takes the sign of the dividend.
  - Most-negative / -1: lo = most-negative value, hi = 0, with no error flag.
- Divide by zero:
  - Result is lo = all ones and hi = dividend as sampled.
  - DIV gives the same result.
  - Full latency still applies, so timing stays deterministic.
- start_i while busy_o=1 is ignored, including during the FIX cycle. The operands and op of an ignored request are not sampled.
- hi_we_i / lo_we_i:
  - Honoured only in IDLE. They write wdata_i on the edge, and both may be asserted together.
  - Ignored while busy; hazard detection stalls MTHI/MTLO in that case.
- start_i and a write strobe together in IDLE: the write takes effect, then the operation's result later overwrites HI/LO.
- hi_o and lo_o hold their value between updates and do not change during RUN.

Test Plan:
- MULTU, WIDTH=32, 0xFFFFFFFF x 0xFFFFFFFF -> after 33 busy cycles, done_o pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT, -7 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV, -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU, 100 / 7 -> lo=14, hi=2.
- DIVU by zero, 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234.
- Control corner cases:
  - Reset mid-RUN: rst_i at cycle 10 -> busy_o=0, hi=lo=0, no done_o pulse.
  - start_i during busy -> ignored, first result intact.
  - MTHI 0xA5A5A5A5 in IDLE -> hi_o=0xA5A5A5A5 next cycle.
  - MTLO during busy -> lo_o unchanged.
